// File: rtl/tpu_package.sv
// Shared TPU types and constants used by the accumulator readout path.
package tpu_package;

    localparam int MUL_SIZE  = 32;
    localparam int ACC_W     = 32;
    localparam int ACC_ROW_W = MUL_SIZE * ACC_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } readout_state_t;

endpackage

// File: rtl/accum_readout_fifo.sv
// Small synchronous FIFO that holds prefetched accumulator rows.
// The head entry is presented straight from storage flops so the output is
// stable while the consumer stalls. Popping an empty FIFO is a no-op.
module accum_readout_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Row storage; contents are only meaningful behind valid pointers, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/accumulator_readout_unit.sv
// Reads a contiguous run of accumulator rows and streams them out over
// valid/ready. Reads are issued only while FIFO occupancy plus reads still
// in the memory pipeline leave room, so returning data always has a slot.
module accumulator_readout_unit
    import tpu_package::*;
#(
    parameter int MUL_SIZE   = tpu_package::MUL_SIZE,
    parameter int ACC_W      = tpu_package::ACC_W,
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [ADDR_W-1:0]         base_addr_i,
    input  logic [ADDR_W:0]           num_rows_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      accum_rd_en_o,
    output logic [ADDR_W-1:0]         accum_rd_addr_o,
    input  logic [MUL_SIZE*ACC_W-1:0] accum_rd_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [MUL_SIZE*ACC_W-1:0] out_data_o,
    output logic [ADDR_W-1:0]         out_row_o,
    output logic                      out_last_o
);

    localparam int ROW_W = MUL_SIZE * ACC_W;
    localparam int NR_W  = ADDR_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    readout_state_t state;
    readout_state_t state_next;

    logic [ADDR_W-1:0]     base_q;
    logic [NR_W-1:0]       num_rows_q;
    logic [NR_W-1:0]       issue_cnt;
    logic [ADDR_W-1:0]     row_cnt;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic [RD_LATENCY:0]   rd_pipe_shift;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  credit_ok;
    logic                  issue;
    logic                  last_issue;
    logic                  handshake;
    int                    inflight;

    // Count reads issued to memory whose data has not yet been captured.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight += int'(rd_pipe[i]);
        end
    end

    assign credit_ok       = ~fifo_full && ((int'(fifo_count) + inflight) < FIFO_DEPTH);
    assign issue           = (state == READ) && credit_ok;
    assign last_issue      = issue && (issue_cnt == num_rows_q - NR_W'(1));
    assign accum_rd_addr_o = issue ? (base_q + issue_cnt[ADDR_W-1:0]) : '0;
    assign rd_pipe_shift   = {rd_pipe, issue};

    assign out_valid_o = ~fifo_empty;
    assign handshake   = out_valid_o & out_ready_i;
    assign out_row_o   = row_cnt;
    assign out_last_o  = out_valid_o && ({1'b0, row_cnt} == num_rows_q - NR_W'(1));

    accum_readout_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (rd_pipe[RD_LATENCY-1]),
        .push_data (accum_rd_data_i),
        .pop       (handshake),
        .pop_data  (out_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_next;
    end

    // Run parameters, issue/handshake counters and the read-latency tag pipe.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            base_q     <= '0;
            num_rows_q <= '0;
            issue_cnt  <= '0;
            row_cnt    <= '0;
            rd_pipe    <= '0;
        end else begin
            rd_pipe <= rd_pipe_shift[RD_LATENCY-1:0];
            if ((state == IDLE) && start_i) begin
                base_q     <= base_addr_i;
                num_rows_q <= num_rows_i;
                issue_cnt  <= '0;
                row_cnt    <= '0;
            end else begin
                if (issue)     issue_cnt <= issue_cnt + NR_W'(1);
                if (handshake) row_cnt   <= row_cnt + ADDR_W'(1);
            end
        end
    end

    // Next-state and status outputs; an empty run skips straight to DONE.
    always_comb begin
        state_next    = state;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        accum_rd_en_o = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_next = (num_rows_i == '0) ? DONE : READ;
            end
            READ: begin
                busy_o        = 1'b1;
                accum_rd_en_o = issue;
                if (last_issue) state_next = DRAIN;
            end
            DRAIN: begin
                busy_o = 1'b1;
                if (handshake && out_last_o) state_next = DONE;
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_accumulator_readout_unit.sv
// Scoreboard bench for accumulator_readout_unit: a behavioural accumulator
// memory answers reads, expected addresses and rows are queued at start,
// and a negedge monitor checks every strobe and beat as it appears.
module tb_accumulator_readout_unit;

    localparam int MUL    = 4;
    localparam int ACCW   = 32;
    localparam int ROW_W  = MUL * ACCW;
    localparam int ADDR_W = 10;
    localparam int L      = 3;
    localparam int D      = 5;
    localparam int ROWS   = 1 << ADDR_W;
    localparam logic [ROW_W-1:0] GARBAGE = {MUL{32'hDEADBEEF}};

    typedef struct packed {
        logic [ROW_W-1:0]  data;
        logic [ADDR_W-1:0] row;
        logic              last;
    } exp_row_t;

    logic              clk_i;
    logic              rst_i;
    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [ADDR_W:0]   num_rows_i;
    logic              busy_o;
    logic              done_o;
    logic              accum_rd_en_o;
    logic [ADDR_W-1:0] accum_rd_addr_o;
    logic [ROW_W-1:0]  accum_rd_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [ROW_W-1:0]  out_data_o;
    logic [ADDR_W-1:0] out_row_o;
    logic              out_last_o;

    accumulator_readout_unit #(
        .MUL_SIZE   (MUL),
        .ACC_W      (ACCW),
        .ADDR_W     (ADDR_W),
        .RD_LATENCY (L),
        .FIFO_DEPTH (D)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .base_addr_i     (base_addr_i),
        .num_rows_i      (num_rows_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .accum_rd_en_o   (accum_rd_en_o),
        .accum_rd_addr_o (accum_rd_addr_o),
        .accum_rd_data_i (accum_rd_data_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_data_o      (out_data_o),
        .out_row_o       (out_row_o),
        .out_last_o      (out_last_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int run_e0   = 0;
    int ready_mode = 0;

    logic [ROW_W-1:0]  mem [ROWS];
    logic [L-1:0]      pend_v = '0;
    logic [ADDR_W-1:0] pend_a [L];

    exp_row_t          exp_rows [$];
    logic [ADDR_W-1:0] exp_addr [$];

    int run_rd_cnt, run_acc_cnt, first_rd, first_valid, last_valid, done_rel;
    int done_cnt = 0;
    int beat_total = 0;
    int run_done_base;
    logic busy_at_done;

    // Free-running clock and edge counter used for relative cycle numbers.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    // Behavioural accumulator memory: each strobe returns its row L cycles later.
    always @(posedge clk_i) begin
        for (int i = L - 1; i > 0; i--) begin
            pend_v[i] <= pend_v[i-1];
            pend_a[i] <= pend_a[i-1];
        end
        pend_v[0] <= accum_rd_en_o;
        pend_a[0] <= accum_rd_addr_o;
    end

    assign accum_rd_data_i = pend_v[L-1] ? mem[pend_a[L-1]] : GARBAGE;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Downstream ready pattern, updated just after each rising edge.
    initial begin
        out_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (ready_mode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = !(((cyc - run_e0 + 1) >= 4) && ((cyc - run_e0 + 1) <= 12));
                default: out_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: checks read strobes, credit limit, stall stability and output beats.
    logic              prev_stall = 1'b0;
    logic [ROW_W-1:0]  prev_data;
    logic [ADDR_W-1:0] prev_row;
    logic              prev_last;
    int                rel;
    exp_row_t          e_mon;
    logic [ADDR_W-1:0] a_mon;

    always @(negedge clk_i) begin
        rel = cyc - run_e0 + 1;
        if (rst_i) begin
            if (accum_rd_en_o) begin
                run_rd_cnt++;
                if (first_rd < 0) first_rd = rel;
                n_checks++;
                if (exp_addr.size() == 0) begin
                    n_errors++;
                    $display("[TB] FAIL rd_addr: got strobe at %0d, required no strobe", accum_rd_addr_o);
                end else begin
                    a_mon = exp_addr.pop_front();
                    if (accum_rd_addr_o !== a_mon) begin
                        n_errors++;
                        $display("[TB] FAIL rd_addr: got %0d, required %0d", accum_rd_addr_o, a_mon);
                    end
                end
                n_checks++;
                if (run_rd_cnt - run_acc_cnt > D) begin
                    n_errors++;
                    $display("[TB] FAIL credit: got outstanding=%0d, required <= %0d",
                             run_rd_cnt - run_acc_cnt, D);
                end
            end
            if (prev_stall) begin
                n_checks++;
                if (!out_valid_o || out_data_o !== prev_data || out_row_o !== prev_row ||
                    out_last_o !== prev_last) begin
                    n_errors++;
                    $display("[TB] FAIL stall_stable: got valid=%0b row=%0d last=%0b, required valid=1 row=%0d last=%0b",
                             out_valid_o, out_row_o, out_last_o, prev_row, prev_last);
                end
            end
            if (out_valid_o && first_valid < 0) first_valid = rel;
            if (out_valid_o && out_ready_i) begin
                run_acc_cnt++;
                beat_total++;
                last_valid = rel;
                n_checks++;
                if (exp_rows.size() == 0) begin
                    n_errors++;
                    $display("[TB] FAIL beat: got row=%0d, required no beat", out_row_o);
                end else begin
                    e_mon = exp_rows.pop_front();
                    if (out_data_o !== e_mon.data || out_row_o !== e_mon.row || out_last_o !== e_mon.last) begin
                        n_errors++;
                        $display("[TB] FAIL beat: got row=%0d last=%0b data=%h, required row=%0d last=%0b data=%h",
                                 out_row_o, out_last_o, out_data_o, e_mon.row, e_mon.last, e_mon.data);
                    end
                end
            end
            if (done_o) begin
                done_cnt++;
                if (done_rel < 0) begin
                    done_rel     = rel;
                    busy_at_done = busy_o;
                end
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_data  = out_data_o;
            prev_row   = out_row_o;
            prev_last  = out_last_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Queue the expected strobes and rows for a run, then issue the start pulse.
    task automatic applyStimulus(input int base, input int nrows, input int mode);
        exp_row_t e;
        int a;
        @(negedge clk_i);
        ready_mode = mode;
        for (int r = 0; r < nrows; r++) begin
            a = (base + r) % ROWS;
            exp_addr.push_back(ADDR_W'(a));
            e.data = mem[a];
            e.row  = ADDR_W'(r);
            e.last = (r == nrows - 1);
            exp_rows.push_back(e);
        end
        run_rd_cnt    = 0;
        run_acc_cnt   = 0;
        first_rd      = -1;
        first_valid   = -1;
        last_valid    = -1;
        done_rel      = -1;
        busy_at_done  = 1'b1;
        run_done_base = done_cnt;
        start_i       = 1'b1;
        base_addr_i   = ADDR_W'(base);
        num_rows_i    = (ADDR_W+1)'(nrows);
        @(posedge clk_i);
        #1;
        run_e0  = cyc;
        start_i = 1'b0;
        @(negedge clk_i);
        checkOutput("busy_after_start", longint'(busy_o), longint'(nrows != 0));
    endtask

    // Wait (bounded) for done, then check the run as a whole.
    task automatic waitRunDone(input int nrows, input bit timing);
        int waited = 0;
        while (done_rel < 0 && waited < 3000) begin
            @(negedge clk_i);
            waited++;
        end
        repeat (4) @(negedge clk_i);
        checkOutput("done_seen", longint'(done_rel >= 0), 1);
        checkOutput("done_pulses", done_cnt - run_done_base, 1);
        checkOutput("busy_at_done", longint'(busy_at_done), 0);
        checkOutput("rows_accepted", run_acc_cnt, nrows);
        checkOutput("reads_issued", run_rd_cnt, nrows);
        checkOutput("rows_left", exp_rows.size(), 0);
        checkOutput("addrs_left", exp_addr.size(), 0);
        if (timing) begin
            if (nrows == 0) begin
                checkOutput("done_cycle", done_rel, 1);
                checkOutput("no_valid", first_valid, -1);
            end else begin
                checkOutput("first_rd_cycle", first_rd, 1);
                checkOutput("first_valid_cycle", first_valid, L + 2);
                checkOutput("last_valid_cycle", last_valid, nrows + L + 1);
                checkOutput("done_cycle", done_rel, nrows + L + 2);
            end
        end
        exp_rows.delete();
        exp_addr.delete();
    endtask

    int w;
    int abort_done_base;
    int abort_beat_base;

    initial begin
        rst_i       = 1'b1;
        start_i     = 1'b0;
        base_addr_i = '0;
        num_rows_i  = '0;
        for (int i = 0; i < ROWS; i++) begin
            for (int k = 0; k < MUL; k++) mem[i][k*32 +: 32] = $urandom;
        end
        #1 rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("reset_busy", longint'(busy_o), 0);
        checkOutput("reset_done", longint'(done_o), 0);
        checkOutput("reset_rd_en", longint'(accum_rd_en_o), 0);
        checkOutput("reset_rd_addr", longint'(accum_rd_addr_o), 0);
        checkOutput("reset_valid", longint'(out_valid_o), 0);
        checkOutput("reset_row", longint'(out_row_o), 0);
        checkOutput("reset_last", longint'(out_last_o), 0);
        checkOutput("reset_data_zero", longint'(out_data_o != '0), 0);
        @(posedge clk_i);
        #2 rst_i = 1'b1;

        $display("[TB] basic run: base 0, 8 rows");
        applyStimulus(0, 8, 0);
        waitRunDone(8, 1);

        $display("[TB] address wrap: base 1020, 8 rows");
        applyStimulus(1020, 8, 0);
        waitRunDone(8, 1);

        $display("[TB] empty run");
        applyStimulus(0, 0, 0);
        waitRunDone(0, 1);

        $display("[TB] 16 rows with a ready stall, plus a start while busy");
        applyStimulus(100, 16, 1);
        repeat (2) @(negedge clk_i);
        start_i     = 1'b1;
        base_addr_i = ADDR_W'(7);
        num_rows_i  = (ADDR_W+1)'(3);
        @(negedge clk_i);
        start_i = 1'b0;
        waitRunDone(16, 0);

        $display("[TB] 100 rows with random ready");
        applyStimulus(int'($urandom_range(0, ROWS - 1)), 100, 2);
        waitRunDone(100, 0);

        for (int n = 0; n < 3; n++) begin
            applyStimulus(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(1, 30)), 2);
            waitRunDone(num_rows_i, 0);
        end

        $display("[TB] reset in the middle of a 20 row run");
        applyStimulus(500, 20, 0);
        w = 0;
        while (run_rd_cnt < 5 && w < 200) begin
            @(negedge clk_i);
            w++;
        end
        checkOutput("abort_reached_row5", longint'(run_rd_cnt >= 5), 1);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        exp_rows.delete();
        exp_addr.delete();
        abort_done_base = done_cnt;
        abort_beat_base = beat_total;
        @(negedge clk_i);
        checkOutput("abort_busy", longint'(busy_o), 0);
        checkOutput("abort_valid", longint'(out_valid_o), 0);
        checkOutput("abort_rd_en", longint'(accum_rd_en_o), 0);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        repeat (6) @(negedge clk_i);
        checkOutput("abort_no_done", done_cnt - abort_done_base, 0);
        checkOutput("abort_no_beats", beat_total - abort_beat_base, 0);
        applyStimulus(40, 4, 0);
        waitRunDone(4, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
